core_ibus_arb: RTL and testbench

- Two-requester arbiter and sequencer for the core's single AHB-Lite instruction master port.
- Requester 0 is the fetch unit (read-only opcode fetch). Requester 1 is a loader/debug port that can read and write.
- One transfer is in flight at a time: SINGLE, word-sized, non-locked.
- Sits inside the core between the fetch and loader logic and the external instruction bus.

---
 rtl/core_ibus_arb.sv | 197 +++++++++++++++++++
 tb/tb_core_ibus_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/core_ibus_arb.sv
// core_ibus_arb
// -------------
// Arbitrates between the fetch unit (requester 0, read-only) and the
// loader/debug port (requester 1, read/write) for the core's single AHB-Lite
// instruction master. Only one SINGLE, word-sized, non-locked transfer is in
// flight at a time: IDLE -> ADDR -> DATA -> IDLE.
//
// Ports
//   i_Clk, i_RstN                 clock, synchronous active-low reset
//   i_Req0/i_Addr0                requester 0 request and address
//   o_Gnt0/o_Done0                requester 0 address-accepted / completion pulses
//   i_Req1/i_Addr1/i_Wr1/i_Wdata1 requester 1 request, address, write flag, data
//   o_Gnt1/o_Done1                requester 1 address-accepted / completion pulses
//   o_Rdata/o_Err                 response data and error, valid with a Done pulse
//   o_Ih*                         AHB-Lite master address/control/write data
//   i_Ihrdata/i_Ihready/i_Ihresp  AHB-Lite slave response
module core_ibus_arb #(
    parameter int P_AW    = 32,
    parameter int P_DW    = 32,
    parameter int P_RR_EN = 1
) (
    input  logic            i_Clk,
    input  logic            i_RstN,
    input  logic            i_Req0,
    input  logic [P_AW-1:0] i_Addr0,
    output logic            o_Gnt0,
    output logic            o_Done0,
    input  logic            i_Req1,
    input  logic [P_AW-1:0] i_Addr1,
    input  logic            i_Wr1,
    input  logic [P_DW-1:0] i_Wdata1,
    output logic            o_Gnt1,
    output logic            o_Done1,
    output logic [P_DW-1:0] o_Rdata,
    output logic            o_Err,
    output logic [P_AW-1:0] o_Ihaddr,
    output logic            o_Ihwrite,
    output logic [3:0]      o_Ihprot,
    output logic [2:0]      o_Ihsize,
    output logic [2:0]      o_Ihburst,
    output logic [1:0]      o_Ihtrans,
    output logic            o_Ihmstlock,
    output logic [P_DW-1:0] o_Ihwdata,
    input  logic [P_DW-1:0] i_Ihrdata,
    input  logic            i_Ihready,
    input  logic            i_Ihresp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [P_AW-1:0] addr_q, addr_d;
    logic            wr_q, wr_d;
    logic [P_DW-1:0] wdata_q, wdata_d;
    logic            win_q, win_d;       // requester owning the current transfer
    logic            last_q, last_d;     // requester granted most recently
    logic [P_DW-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic [1:0]      trans_q, trans_d;
    logic [3:0]      prot_q, prot_d;
    logic            pick_s;
    logic            gnt0_s, gnt1_s;

    // Winner selection for the IDLE state; only meaningful when a request is up.
    always_comb begin
        pick_s = 1'b0;
        if (i_Req0 && i_Req1) begin
            if (P_RR_EN != 0) begin
                pick_s = ~last_q;
            end else begin
                pick_s = 1'b0;
            end
        end else begin
            pick_s = i_Req1;
        end
    end

    // Next-state, transfer latching, response capture and grant decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        win_d   = win_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Req0 || i_Req1) begin
                    win_d   = pick_s;
                    last_d  = pick_s;
                    addr_d  = pick_s ? i_Addr1 : i_Addr0;
                    wr_d    = pick_s ? i_Wr1 : 1'b0;
                    wdata_d = pick_s ? i_Wdata1 : {P_DW{1'b0}};
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (i_Ihready) begin
                    gnt0_s  = ~win_q;
                    gnt1_s  = win_q;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (i_Ihready) begin
                    // Writes leave the last read data visible.
                    if (!wr_q) begin
                        rdata_d = i_Ihrdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    err_d   = i_Ihresp;
                    done0_d = ~win_q;
                    done1_d = win_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Bus control is registered against the state being entered.
        if (state_d == ST_ADDR) begin
            trans_d = 2'b10;
            prot_d  = {2'b00, 1'b1, win_d};
        end else begin
            trans_d = 2'b00;
            prot_d  = 4'b0000;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_Clk) begin
        if (!i_RstN) begin
            state_q <= ST_IDLE;
            addr_q  <= {P_AW{1'b0}};
            wr_q    <= 1'b0;
            wdata_q <= {P_DW{1'b0}};
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= {P_DW{1'b0}};
            err_q   <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            trans_q <= 2'b00;
            prot_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            win_q   <= win_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            trans_q <= trans_d;
            prot_q  <= prot_d;
        end
    end

    // Grant depends on HREADY in the address phase, so it is decoded live.
    assign o_Gnt0      = gnt0_s;
    assign o_Gnt1      = gnt1_s;
    assign o_Done0     = done0_q;
    assign o_Done1     = done1_q;
    assign o_Rdata     = rdata_q;
    assign o_Err       = err_q;
    assign o_Ihaddr    = addr_q;
    assign o_Ihwrite   = wr_q;
    assign o_Ihprot    = prot_q;
    assign o_Ihtrans   = trans_q;
    assign o_Ihwdata   = wdata_q;
    assign o_Ihsize    = 3'b010;
    assign o_Ihburst   = 3'b000;
    assign o_Ihmstlock = 1'b0;

endmodule

// File: tb/tb_core_ibus_arb.sv
// Bench for core_ibus_arb: a round-robin instance (index 0) and a fixed-priority
// instance (index 1) share all inputs; a transaction-level model predicts the
// winner, bus phases, grants and completions of each.
module tb_core_ibus_arb;

    logic        clk = 1'b0;
    logic        rst_n, req0, req1, wr1, ready, resp;
    logic [31:0] addr0, addr1, wdata1, hrdata;

    logic [1:0]  gnt0, gnt1, done0, done1, err, hwrite, lock;
    logic [31:0] rdata [2];
    logic [31:0] haddr [2];
    logic [31:0] hwdata [2];
    logic [3:0]  hprot [2];
    logic [2:0]  hsize [2];
    logic [2:0]  hburst [2];
    logic [1:0]  htrans [2];

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    logic        last_rr;
    logic        win [2];
    logic        pending;
    logic [31:0] exp_rdata [2];
    logic        exp_err;

    always #5 clk = ~clk;

    core_ibus_arb #(.P_AW(32), .P_DW(32), .P_RR_EN(1)) dut_rr (
        .i_Clk(clk), .i_RstN(rst_n),
        .i_Req0(req0), .i_Addr0(addr0), .o_Gnt0(gnt0[0]), .o_Done0(done0[0]),
        .i_Req1(req1), .i_Addr1(addr1), .i_Wr1(wr1), .i_Wdata1(wdata1),
        .o_Gnt1(gnt1[0]), .o_Done1(done1[0]),
        .o_Rdata(rdata[0]), .o_Err(err[0]),
        .o_Ihaddr(haddr[0]), .o_Ihwrite(hwrite[0]), .o_Ihprot(hprot[0]),
        .o_Ihsize(hsize[0]), .o_Ihburst(hburst[0]), .o_Ihtrans(htrans[0]),
        .o_Ihmstlock(lock[0]), .o_Ihwdata(hwdata[0]),
        .i_Ihrdata(hrdata), .i_Ihready(ready), .i_Ihresp(resp)
    );

    core_ibus_arb #(.P_AW(32), .P_DW(32), .P_RR_EN(0)) dut_fp (
        .i_Clk(clk), .i_RstN(rst_n),
        .i_Req0(req0), .i_Addr0(addr0), .o_Gnt0(gnt0[1]), .o_Done0(done0[1]),
        .i_Req1(req1), .i_Addr1(addr1), .i_Wr1(wr1), .i_Wdata1(wdata1),
        .o_Gnt1(gnt1[1]), .o_Done1(done1[1]),
        .o_Rdata(rdata[1]), .o_Err(err[1]),
        .o_Ihaddr(haddr[1]), .o_Ihwrite(hwrite[1]), .o_Ihprot(hprot[1]),
        .o_Ihsize(hsize[1]), .o_Ihburst(hburst[1]), .o_Ihtrans(htrans[1]),
        .o_Ihmstlock(lock[1]), .o_Ihwdata(hwdata[1]),
        .i_Ihrdata(hrdata), .i_Ihready(ready), .i_Ihresp(resp)
    );

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Checks of an IDLE cycle: no transfer on the bus, Done only for a just-finished transfer.
    task automatic check_idle();
        for (int d = 0; d < 2; d++) begin
            chk_eq($sformatf("idle_htrans[%0d]", d), htrans[d], 2'b00);
            chk_eq($sformatf("idle_gnt0[%0d]", d), gnt0[d], 1'b0);
            chk_eq($sformatf("idle_gnt1[%0d]", d), gnt1[d], 1'b0);
            chk_eq($sformatf("done0[%0d]", d), done0[d], pending && !win[d]);
            chk_eq($sformatf("done1[%0d]", d), done1[d], pending && win[d]);
            chk_eq($sformatf("const_ctl[%0d]", d), {hsize[d], hburst[d], lock[d]}, {3'b010, 3'b000, 1'b0});
            if (pending) begin
                chk_eq($sformatf("rdata[%0d]", d), rdata[d], exp_rdata[d]);
                chk_eq($sformatf("err[%0d]", d), err[d], exp_err);
            end
        end
        pending = 1'b0;
    endtask

    // One arbitration cycle and, if anything is requested, the full transfer.
    task automatic xfer(input logic r0, input logic r1, input logic [31:0] a0, input logic [31:0] a1,
                        input logic w1, input logic [31:0] wd, input int aw, input int dw,
                        input logic er, input logic [31:0] rd);
        @(negedge clk);
        rst_n = 1'b1; req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
        wr1 = w1; wdata1 = wd; ready = 1'b1; resp = 1'b0;
        #1;
        check_idle();
        if (r0 || r1) begin
            win[0] = (r0 && r1) ? ~last_rr : r1;
            win[1] = (r0 && r1) ? 1'b0 : r1;
            last_rr = win[0];
            @(posedge clk);
            for (int i = 0; i <= aw; i++) begin
                @(negedge clk);
                ready = (i == aw);
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk_eq($sformatf("addr_htrans[%0d]", d), htrans[d], 2'b10);
                    chk_eq($sformatf("haddr[%0d]", d), haddr[d], win[d] ? a1 : a0);
                    chk_eq($sformatf("hwrite[%0d]", d), hwrite[d], win[d] && w1);
                    chk_eq($sformatf("hprot[%0d]", d), hprot[d], {3'b001, win[d]});
                    chk_eq($sformatf("gnt0[%0d]", d), gnt0[d], ready && !win[d]);
                    chk_eq($sformatf("gnt1[%0d]", d), gnt1[d], ready && win[d]);
                    chk_eq($sformatf("addr_done[%0d]", d), {done0[d], done1[d]}, 2'b00);
                end
                @(posedge clk);
            end
            for (int i = 0; i <= dw; i++) begin
                @(negedge clk);
                ready  = (i == dw);
                resp   = er && (i >= dw - 1);
                hrdata = rd;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk_eq($sformatf("data_htrans[%0d]", d), htrans[d], 2'b00);
                    chk_eq($sformatf("data_gnt[%0d]", d), {gnt0[d], gnt1[d]}, 2'b00);
                    chk_eq($sformatf("data_done[%0d]", d), {done0[d], done1[d]}, 2'b00);
                    if (win[d]) begin
                        chk_eq($sformatf("hwdata[%0d]", d), hwdata[d], wd);
                    end
                end
                @(posedge clk);
            end
            for (int d = 0; d < 2; d++) begin
                if (!(win[d] && w1)) begin
                    exp_rdata[d] = rd;
                end
            end
            exp_err = er;
            pending = 1'b1;
        end else begin
            @(posedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 32'h0; addr1 = 32'h4;
        wr1 = 1'b0; wdata1 = 32'h0; ready = 1'b1; resp = 1'b0; hrdata = 32'h0;
        last_rr = 1'b1; win[0] = 1'b0; win[1] = 1'b0; pending = 1'b0;
        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0; exp_err = 1'b0;

        // reset with both requests asserted
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk_eq($sformatf("rst_htrans[%0d]", d), htrans[d], 2'b00);
                chk_eq($sformatf("rst_gntdone[%0d]", d), {gnt0[d], gnt1[d], done0[d], done1[d]}, 4'b0000);
                chk_eq($sformatf("rst_rdata[%0d]", d), {rdata[d], err[d]}, 33'h0);
            end
        end

        // first tie after reset goes to requester 0 in both modes
        xfer(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0300, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0BAD_F00D);
        // zero-wait fetch
        xfer(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF);
        // both held high: round robin alternates, fixed priority keeps requester 0
        for (int k = 0; k < 4; k++) begin
            xfer(1'b1, 1'b1, 32'h1000 + k * 4, 32'h2000 + k * 4, 1'b0, 32'h0, 0, 0, 1'b0, 32'hA5A5_0000 + k);
        end
        // loader write with 3 data-phase wait states
        xfer(1'b0, 1'b1, 32'h0, 32'h0000_0040, 1'b1, 32'h1234_5678, 0, 3, 1'b0, 32'hFFFF_FFFF);
        // two-cycle ERROR on a fetch
        xfer(1'b1, 1'b0, 32'h0000_0800, 32'h0, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0013);
        xfer(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0);

        // reset during a data-phase wait
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b0; addr0 = 32'h0000_0900; ready = 1'b1; resp = 1'b0;
        #1;
        check_idle();
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_eq($sformatf("mrst_htrans[%0d]", d), htrans[d], 2'b00);
            chk_eq($sformatf("mrst_gntdone[%0d]", d), {gnt0[d], gnt1[d], done0[d], done1[d]}, 4'b0000);
            chk_eq($sformatf("mrst_rdata[%0d]", d), rdata[d], 32'h0);
        end
        last_rr = 1'b1; pending = 1'b0;
        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0; exp_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_eq($sformatf("mrst_nodone[%0d]", d), {done0[d], done1[d]}, 2'b00);
        end
        @(posedge clk);
        // fresh transfers after the abort; tie must again favour requester 0
        xfer(1'b1, 1'b1, 32'h0000_0A00, 32'h0000_0B00, 1'b1, 32'h5555_AAAA, 0, 0, 1'b0, 32'h7777_1111);
        xfer(1'b1, 1'b1, 32'h0000_0A04, 32'h0000_0B04, 1'b1, 32'h6666_BBBB, 1, 0, 1'b0, 32'h7777_2222);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            logic r0, r1, w, e;
            int   aw, dw;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            aw = $urandom_range(0, 2);
            dw = $urandom_range(0, 3);
            e  = (dw > 0) && ($urandom_range(0, 3) == 0);
            xfer(r0, r1, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, w, $urandom, aw, dw, e, $urandom);
        end
        xfer(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
